// File: rtl/inst_mem_burst.sv
// Burst read engine: turns one I-cache refill request into BLOCK_SIZE sequential BRAM reads.
// Define INST_MEM_STATS_EN to add saturating burst/abort counters (stat_bursts, stat_aborts).
module inst_mem_burst #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 16,
   parameter int BLOCK_OFFSET_WIDTH = 5,
   parameter int READ_LATENCY       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_enable,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_read,
   output logic                  mem_read_valid,
   output logic                  mem_last,
   output logic                  bram_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  busy
`ifdef INST_MEM_STATS_EN
   ,
   output logic [31:0]           stat_bursts,
   output logic [31:0]           stat_aborts
`endif
);

   localparam int TAG_WIDTH = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;
   localparam logic [BLOCK_OFFSET_WIDTH-1:0] CNT_MAX = {BLOCK_OFFSET_WIDTH{1'b1}};
   localparam logic [BLOCK_OFFSET_WIDTH-1:0] CNT_ONE = {{(BLOCK_OFFSET_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = {{TAG_WIDTH{1'b0}}, {BLOCK_OFFSET_WIDTH{1'b1}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      DRAIN   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                        state_q;
   logic [ADDR_WIDTH-1:0]         base_q;
   logic [BLOCK_OFFSET_WIDTH-1:0] cnt_q;
   logic [BLOCK_OFFSET_WIDTH-1:0] cnt_d;
   logic [ADDR_WIDTH-1:0]         bram_addr_q;
   logic [ADDR_WIDTH-1:0]         bram_addr_d;
   logic                          bram_en_q;
   logic                          busy_q;
   logic [READ_LATENCY-1:0]       pv_q;
   logic [READ_LATENCY-1:0]       pl_q;
   logic [DATA_WIDTH-1:0]         rdata_q;
   logic                          rvalid_q;
   logic                          rlast_q;
   logic                          abort_s;
   logic                          drain_done_s;
   logic                          head_v_s;
   logic                          head_l_s;

   // Next issue address, abort detection and "no read still in flight before the head" check.
   always_comb begin
      cnt_d        = cnt_q + CNT_ONE;
      bram_addr_d  = base_q | {{TAG_WIDTH{1'b0}}, cnt_d};
      head_v_s     = pv_q[READ_LATENCY-1];
      head_l_s     = pl_q[READ_LATENCY-1];
      abort_s      = ~mem_enable & ((state_q == ISSUE) | (state_q == DRAIN));
      drain_done_s = 1'b1;
      for (int i = 0; i < READ_LATENCY - 1; i++) begin
         drain_done_s = drain_done_s & ~pv_q[i];
      end
   end

   // Burst FSM, {valid,last} latency pipe and registered return port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= {ADDR_WIDTH{1'b0}};
         cnt_q       <= {BLOCK_OFFSET_WIDTH{1'b0}};
         bram_addr_q <= {ADDR_WIDTH{1'b0}};
         bram_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         pv_q        <= {READ_LATENCY{1'b0}};
         pl_q        <= {READ_LATENCY{1'b0}};
         rdata_q     <= {DATA_WIDTH{1'b0}};
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
      end else begin
         // An abort wipes every in-flight tag so no stale beat can surface later.
         pv_q[0] <= bram_en_q & ~abort_s;
         pl_q[0] <= bram_en_q & (cnt_q == CNT_MAX) & ~abort_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1] & ~abort_s;
            pl_q[i] <= pl_q[i-1] & ~abort_s;
         end
         rvalid_q <= head_v_s & ~abort_s;
         rlast_q  <= head_v_s & head_l_s & ~abort_s;
         if (head_v_s) begin
            rdata_q <= bram_dout;
         end

         case (state_q)
            IDLE: begin
               if (mem_enable) begin
                  state_q     <= ISSUE;
                  busy_q      <= 1'b1;
                  bram_en_q   <= 1'b1;
                  base_q      <= mem_addr & ~OFFSET_MASK;
                  bram_addr_q <= mem_addr & ~OFFSET_MASK;
                  cnt_q       <= {BLOCK_OFFSET_WIDTH{1'b0}};
               end
            end
            ISSUE: begin
               if (abort_s) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  bram_en_q <= 1'b0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q   <= DRAIN;
                  bram_en_q <= 1'b0;
               end else begin
                  cnt_q       <= cnt_d;
                  bram_addr_q <= bram_addr_d;
               end
            end
            DRAIN: begin
               if (abort_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (drain_done_s) begin
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               // Holding here until enable drops guarantees one burst per request.
               if (!mem_enable) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               bram_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_read       = rdata_q;
   assign mem_read_valid = rvalid_q;
   assign mem_last       = rlast_q;
   assign bram_en        = bram_en_q;
   assign bram_addr      = bram_addr_q;
   assign busy           = busy_q;

`ifdef INST_MEM_STATS_EN
   logic [31:0] bursts_q;
   logic [31:0] aborts_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Saturating activity counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bursts_q <= 32'd0;
         aborts_q <= 32'd0;
      end else begin
         if (head_v_s & head_l_s & ~abort_s) begin
            bursts_q <= sat_inc(bursts_q);
         end
         if (abort_s) begin
            aborts_q <= sat_inc(aborts_q);
         end
      end
   end

   assign stat_bursts = bursts_q;
   assign stat_aborts = aborts_q;
`endif

endmodule

// File: tb/tb_inst_mem_burst.sv
// Self-checking bench for inst_mem_burst: a READ_LATENCY=1 instance plus a READ_LATENCY=3 instance
// sharing the request inputs, each with its own behavioural BRAM.
module tb_inst_mem_burst;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_enable;
   logic [15:0] mem_addr;

   logic [31:0] mem_read,  mem_read3;
   logic        mem_read_valid, mem_read_valid3;
   logic        mem_last, mem_last3;
   logic        bram_en, bram_en3;
   logic [15:0] bram_addr, bram_addr3;
   logic [31:0] bram_dout = 32'd0;
   logic [31:0] b3_s1 = 32'd0, b3_s2 = 32'd0, b3_s3 = 32'd0;
   logic        busy, busy3;
`ifdef INST_MEM_STATS_EN
   logic [31:0] stat_bursts, stat_aborts, stat_bursts3, stat_aborts3;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inst_mem_burst #(.READ_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_addr(mem_addr),
      .mem_read(mem_read), .mem_read_valid(mem_read_valid), .mem_last(mem_last),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout), .busy(busy)
`ifdef INST_MEM_STATS_EN
      , .stat_bursts(stat_bursts), .stat_aborts(stat_aborts)
`endif
   );

   inst_mem_burst #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_addr(mem_addr),
      .mem_read(mem_read3), .mem_read_valid(mem_read_valid3), .mem_last(mem_last3),
      .bram_en(bram_en3), .bram_addr(bram_addr3), .bram_dout(b3_s3), .busy(busy3)
`ifdef INST_MEM_STATS_EN
      , .stat_bursts(stat_bursts3), .stat_aborts(stat_aborts3)
`endif
   );

   function automatic logic [31:0] word(input logic [15:0] a);
      return {a ^ 16'hC0DE, a};
   endfunction

   // BRAM models: one-cycle and three-cycle read latency.
   always @(posedge clk) begin
      if (bram_en) bram_dout <= word(bram_addr);
      if (bram_en3) b3_s1 <= word(bram_addr3);
      b3_s2 <= b3_s1;
      b3_s3 <= b3_s2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Full burst on the latency-1 instance; enable held 'hold' cycles past mem_last.
   // Called at a negedge; cyc counts negedges after enable is raised, so with one
   // cycle of BRAM latency the first beat is seen at cyc 3 (two edges after the
   // edge that samples the request).
   task automatic do_burst(input logic [15:0] addr, input logic [15:0] base, input int hold);
      int issued = 0, bad_addr = 0, beats = 0, bad_data = 0, lasts = 0;
      int last_idx = -1, first_cyc = -1, last_cyc = -1, extra = 0, held = 0, busy_bad = 0;
      mem_addr   = addr;
      mem_enable = 1'b1;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         @(negedge clk);
         if (!busy) busy_bad++;
         if (bram_en) begin
            if (lasts > 0) extra++;
            else begin
               if (bram_addr !== base + 16'(issued)) bad_addr++;
               issued++;
            end
         end
         if (mem_last && !mem_read_valid) bad_data++;
         if (mem_read_valid) begin
            if (lasts > 0) extra++;
            else begin
               if (first_cyc < 0) first_cyc = cyc;
               if (mem_read !== word(base + 16'(beats))) bad_data++;
               if (mem_last) begin
                  lasts    = 1;
                  last_idx = beats;
                  last_cyc = cyc;
               end
               beats++;
            end
         end
         if (lasts > 0) begin
            if (held == hold) break;
            held++;
         end
      end
      mem_enable = 1'b0;
      @(negedge clk);
      chk("burst bram_addr sequence errors", bad_addr, 0);
      chk("burst reads issued", issued, 32);
      chk("burst beats", beats, 32);
      chk("burst data errors", bad_data, 0);
      chk("burst mem_last seen", lasts, 1);
      chk("burst mem_last beat index", last_idx, 31);
      chk("burst first beat cycle", first_cyc, 3);
      chk("burst contiguous span", last_cyc - first_cyc, 31);
      chk("burst extra beats/reads after last", extra, 0);
      chk("burst busy low during burst", busy_bad, 0);
      chk("burst busy after release", busy, 0);
   endtask

   // Drop enable while beat 10 is on the port; the burst must stop cleanly.
   task automatic do_abort(input logic [15:0] addr, input logic [15:0] base);
      int beats = 0, bad = 0, late = 0;
      mem_addr   = addr;
      mem_enable = 1'b1;
      for (int cyc = 0; cyc < 60 && beats < 11; cyc++) begin
         @(negedge clk);
         if (mem_read_valid) begin
            if (mem_read !== word(base + 16'(beats))) bad++;
            beats++;
         end
      end
      mem_enable = 1'b0;
      chk("abort beats before drop", beats, 11);
      chk("abort data errors", bad, 0);
      @(negedge clk);
      chk("abort valid next cycle", mem_read_valid, 0);
      chk("abort busy next cycle", busy, 0);
      chk("abort bram_en next cycle", bram_en, 0);
      repeat (4) begin
         @(negedge clk);
         if (mem_read_valid || mem_last || bram_en || busy) late++;
      end
      chk("abort late activity", late, 0);
   endtask

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] base;
      logic [3:0]  hold;
   } vec_t;

   vec_t vecs [5];
   int   first3, beats3, bad3, last3c, last3i;

   initial begin
      vecs[0] = '{addr: 16'h1234, base: 16'h1220, hold: 4'd0};
      vecs[1] = '{addr: 16'h0000, base: 16'h0000, hold: 4'd0};
      vecs[2] = '{addr: 16'hFFFF, base: 16'hFFE0, hold: 4'd1};
      vecs[3] = '{addr: 16'h0040, base: 16'h0040, hold: 4'd3};
      vecs[4] = '{addr: 16'h5A5F, base: 16'h5A40, hold: 4'd0};

      rst        = 1'b1;
      mem_enable = 1'b0;
      mem_addr   = 16'h0000;
      repeat (2) @(negedge clk);
      chk("reset mem_read", mem_read, 32'd0);
      chk("reset mem_read_valid", mem_read_valid, 0);
      chk("reset mem_last", mem_last, 0);
      chk("reset bram_en", bram_en, 0);
      chk("reset bram_addr", bram_addr, 16'h0000);
      chk("reset busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         do_burst(vecs[v].addr, vecs[v].base, int'(vecs[v].hold));
         @(negedge clk);
      end

      // READ_LATENCY=3: first beat at cyc 5, then 32 gap-free beats.
      first3 = -1; beats3 = 0; bad3 = 0; last3c = -1; last3i = -1;
      mem_addr   = 16'h0000;
      mem_enable = 1'b1;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         @(negedge clk);
         if (mem_read_valid3) begin
            if (first3 < 0) first3 = cyc;
            if (mem_read3 !== word(16'(beats3))) bad3++;
            if (mem_last3) begin
               last3i = beats3;
               last3c = cyc;
            end
            beats3++;
         end
         if (last3c >= 0) break;
      end
      mem_enable = 1'b0;
      @(negedge clk);
      chk("lat3 first beat cycle", first3, 5);
      chk("lat3 beats", beats3, 32);
      chk("lat3 last index", last3i, 31);
      chk("lat3 contiguous span", last3c - first3, 31);
      chk("lat3 data errors", bad3, 0);
      chk("lat3 busy after release", busy3, 0);
      @(negedge clk);

      do_abort(16'h0100, 16'h0100);
      do_burst(16'h0040, 16'h0040, 0);
      @(negedge clk);

      // Asynchronous reset while the issue counter is at 7.
      mem_addr   = 16'h0A13;
      mem_enable = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst mid-issue bram_addr at cnt 7", bram_addr, 16'h0A07);
      chk("rst mid-issue valid before reset", mem_read_valid, 1);
      #2 rst = 1'b1;
      mem_enable = 1'b0;
      #1;
      chk("async rst mem_read", mem_read, 32'd0);
      chk("async rst mem_read_valid", mem_read_valid, 0);
      chk("async rst mem_last", mem_last, 0);
      chk("async rst bram_en", bram_en, 0);
      chk("async rst bram_addr", bram_addr, 16'h0000);
      chk("async rst busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int late = 0;
         repeat (5) begin
            @(negedge clk);
            if (mem_read_valid || mem_read_valid3 || bram_en || busy) late++;
         end
         chk("post-reset pipe empty", late, 0);
      end

`ifdef INST_MEM_STATS_EN
      do_burst(16'h2000, 16'h2000, 0);
      @(negedge clk);
      do_burst(16'h3007, 16'h3000, 1);
      @(negedge clk);
      do_abort(16'h4000, 16'h4000);
      chk("stat_bursts", stat_bursts, 32'd2);
      chk("stat_aborts", stat_aborts, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
